// File: rtl/io_output_bank.sv
// io_output_bank: memory-mapped bank of registered output ports for the CPU
// I/O space. Each port can be written plainly or via set/clear/toggle address
// aliases, always under per-byte enables. A write to port k produces a
// one-cycle wr_strobe[k] pulse. rd_data and hit are combinational so the
// load path can return the current port value.
module io_output_bank #(
    parameter int                N_PORTS   = 5,
    parameter int                DATA_W    = 32,
    parameter logic [5:0]        BASE_WORD = 6'h20,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                        io_clk,
    input  logic                        clr,
    input  logic [31:0]                 addr,
    input  logic [DATA_W-1:0]           datain,
    input  logic [DATA_W/8-1:0]         byte_en,
    input  logic                        write_io_enable,
    output logic [N_PORTS*DATA_W-1:0]   out_port,
    output logic [N_PORTS-1:0]          wr_strobe,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        hit
);

    localparam int         BE_W      = DATA_W / 8;
    localparam logic [6:0] N_PORTS_C = 7'(N_PORTS);

    localparam logic [1:0] MODE_WRITE = 2'b00;
    localparam logic [1:0] MODE_SET   = 2'b01;
    localparam logic [1:0] MODE_CLR   = 2'b10;
    localparam logic [1:0] MODE_TOG   = 2'b11;

    logic [N_PORTS*DATA_W-1:0] out_port_r;
    logic [N_PORTS-1:0]        wr_strobe_r;
    logic [N_PORTS*DATA_W-1:0] port_next_s;
    logic [N_PORTS-1:0]        strobe_next_s;
    logic [5:0]                idx_s;
    logic                      hit_s;
    logic                      wr_accept_s;
    logic [DATA_W-1:0]         rd_data_s;
    logic                      unused_addr_s;

    // Per-byte read-modify-write merge. Disabled bytes always keep the old
    // value; the old value is the pre-edge register contents, so back-to-back
    // set/clear/toggle writes chain without any forwarding.
    function automatic logic [DATA_W-1:0] apply_mode(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] din,
        input logic [BE_W-1:0]   be,
        input logic [1:0]        mode
    );
        logic [DATA_W-1:0] res;
        logic [7:0]        old_b;
        logic [7:0]        din_b;
        logic [7:0]        new_b;
        res = old_val;
        for (int b = 0; b < BE_W; b++) begin
            old_b = old_val[b*8 +: 8];
            din_b = din[b*8 +: 8];
            case (mode)
                MODE_WRITE: new_b = din_b;
                MODE_SET:   new_b = old_b | din_b;
                MODE_CLR:   new_b = old_b & ~din_b;
                MODE_TOG:   new_b = old_b ^ din_b;
                default:    new_b = old_b;
            endcase
            if (be[b]) begin
                res[b*8 +: 8] = new_b;
            end else begin
                res[b*8 +: 8] = old_b;
            end
        end
        return res;
    endfunction

    // Port decode: the subtraction is 6-bit, so addresses below the base wrap
    // to large indices and fail the range compare instead of aliasing.
    always_comb begin
        idx_s       = addr[7:2] - BASE_WORD;
        hit_s       = ({1'b0, idx_s} < N_PORTS_C);
        wr_accept_s = write_io_enable & hit_s;
    end

    // Next-state for every port register and its update strobe.
    always_comb begin
        port_next_s   = out_port_r;
        strobe_next_s = {N_PORTS{1'b0}};
        for (int k = 0; k < N_PORTS; k++) begin
            if (wr_accept_s && (idx_s == 6'(k))) begin
                port_next_s[k*DATA_W +: DATA_W] =
                    apply_mode(out_port_r[k*DATA_W +: DATA_W], datain, byte_en, addr[9:8]);
                strobe_next_s[k] = 1'b1;
            end else begin
                strobe_next_s[k] = 1'b0;
            end
        end
    end

    // Combinational readback of the selected port; zero on a miss.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < N_PORTS; k++) begin
            if (hit_s && (idx_s == 6'(k))) begin
                rd_data_s = out_port_r[k*DATA_W +: DATA_W];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Port registers and strobes; clr overrides any write in flight.
    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            out_port_r  <= {N_PORTS{RESET_VAL}};
            wr_strobe_r <= {N_PORTS{1'b0}};
        end else begin
            out_port_r  <= port_next_s;
            wr_strobe_r <= strobe_next_s;
        end
    end

    // Address bits outside the port/mode fields are intentionally ignored.
    assign unused_addr_s = ^{addr[31:10], addr[1:0]};

    assign out_port  = out_port_r;
    assign wr_strobe = wr_strobe_r;
    assign rd_data   = rd_data_s;
    assign hit       = hit_s;

endmodule
